// File: rtl/timer_counter.sv
// Memory-mapped 32-bit down-counting timer (CTRL/PRESET/COUNT) with one-shot or auto-reload expiry interrupt.
// Reads are combinational in the access cycle; writes land on the clock edge; no backpressure, every access completes at once.
module timer_counter (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  addr,
    input  logic        writeEnable,
    input  logic [31:0] writeData,
    output logic [31:0] readData,
    output logic        irq
);

    typedef struct packed {
        logic       im;
        logic [1:0] mode;
        logic       en;
    } ctrl_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        CNT  = 2'd2,
        INT  = 2'd3
    } state_t;

    localparam logic [1:0] ADDR_CTRL   = 2'd0;
    localparam logic [1:0] ADDR_PRESET = 2'd1;
    localparam logic [1:0] ADDR_COUNT  = 2'd2;
    localparam logic [1:0] MODE_RELOAD = 2'b01;

    ctrl_t       ctrl_q;
    logic [31:0] preset_q;
    logic [31:0] count_q;
    logic        irq_flag_q;
    state_t      state_q;

    always_comb begin
        readData = 32'd0;
        case (addr)
            ADDR_CTRL:   readData = {28'd0, ctrl_q};
            ADDR_PRESET: readData = preset_q;
            ADDR_COUNT:  readData = count_q;
            default:     readData = 32'd0;
        endcase
    end

    // Both terms are flops, so irq has no path from the bus inputs.
    assign irq = ctrl_q.im & irq_flag_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl_q     <= '0;
            preset_q   <= 32'd0;
            count_q    <= 32'd0;
            irq_flag_q <= 1'b0;
            state_q    <= IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (ctrl_q.en) state_q <= LOAD;
                end
                LOAD: begin
                    count_q <= preset_q;
                    state_q <= CNT;
                end
                CNT: begin
                    if (!ctrl_q.en) begin
                        state_q <= IDLE;
                    end else if (count_q > 32'd1) begin
                        count_q <= count_q - 32'd1;
                    end else begin
                        // A zero preset expires here too, so the count never wraps.
                        count_q    <= 32'd0;
                        irq_flag_q <= 1'b1;
                        state_q    <= INT;
                    end
                end
                INT: begin
                    if (ctrl_q.mode == MODE_RELOAD) begin
                        irq_flag_q <= 1'b0;
                        state_q    <= LOAD;
                    end else begin
                        ctrl_q.en <= 1'b0;
                        state_q   <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase

            // Placed last so a bus write overrides same-edge FSM updates of CTRL and the flag.
            if (writeEnable) begin
                case (addr)
                    ADDR_CTRL: begin
                        ctrl_q     <= ctrl_t'(writeData[3:0]);
                        irq_flag_q <= 1'b0;
                    end
                    ADDR_PRESET: preset_q <= writeData;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_timer_counter.sv
// Scoreboard bench for timer_counter: a time-based reference model predicts each cycle's read data and irq.
module tb_timer_counter;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  addr;
    logic        writeEnable;
    logic [31:0] writeData;
    logic [31:0] readData;
    logic        irq;

    always #5 clk = ~clk;

    timer_counter dut (
        .clk         (clk),
        .reset       (reset),
        .addr        (addr),
        .writeEnable (writeEnable),
        .writeData   (writeData),
        .readData    (readData),
        .irq         (irq)
    );

    typedef struct packed {
        logic [31:0] rd;
        logic        irq;
        logic [1:0]  a;
    } exp_t;

    exp_t sbq[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    // Reference model: tracks when the next load / expiry happens in absolute edge numbers.
    bit [3:0]  m_ctrl;
    bit [31:0] m_preset;
    bit [31:0] m_count;
    bit        m_flag;
    bit        m_run;
    bit [31:0] m_pl;
    longint    m_s;
    longint    m_x;
    longint    m_load_at;
    longint    m_int_at;
    longint    t;

    function automatic void model_reset();
        m_ctrl    = 4'd0;
        m_preset  = 32'd0;
        m_count   = 32'd0;
        m_flag    = 1'b0;
        m_run     = 1'b0;
        m_pl      = 32'd0;
        m_s       = 0;
        m_x       = 0;
        m_load_at = -1;
        m_int_at  = -1;
    endfunction

    function automatic bit [31:0] model_read(input bit [1:0] a);
        case (a)
            2'd0:    return {28'd0, m_ctrl};
            2'd1:    return m_preset;
            2'd2:    return m_count;
            default: return 32'd0;
        endcase
    endfunction

    function automatic void model_edge(input bit rst, input bit we, input bit [1:0] a, input bit [31:0] d);
        bit     en_old;
        bit     reload;
        longint rem;
        en_old = m_ctrl[0];
        reload = (m_ctrl[2:1] == 2'b01);
        if (rst) begin
            model_reset();
        end else begin
            if (m_load_at == t) begin
                m_load_at = -1;
                m_pl      = m_preset;
                m_count   = m_preset;
                m_s       = t;
                m_x       = t + ((m_preset == 32'd0) ? 1 : longint'(m_preset));
                m_run     = 1'b1;
            end else if (m_run) begin
                if (!en_old) begin
                    m_run = 1'b0;
                end else if (t == m_x) begin
                    m_count  = 32'd0;
                    m_flag   = 1'b1;
                    m_run    = 1'b0;
                    m_int_at = t + 1;
                end else begin
                    rem     = longint'(m_pl) - (t - m_s);
                    m_count = rem[31:0];
                end
            end else if (m_int_at == t) begin
                m_int_at = -1;
                if (reload) begin
                    m_flag    = 1'b0;
                    m_load_at = t + 1;
                end else begin
                    m_ctrl[0] = 1'b0;
                end
            end else if (en_old) begin
                m_load_at = t + 1;
            end
            if (we && a == 2'd0) begin
                m_ctrl = d[3:0];
                m_flag = 1'b0;
            end
            if (we && a == 2'd1) m_preset = d;
        end
        t = t + 1;
    endfunction

    task automatic cycle(input bit rst, input bit we, input bit [1:0] a, input bit [31:0] d);
        exp_t e;
        reset       = rst;
        writeEnable = we;
        addr        = a;
        writeData   = d;
        e.rd  = model_read(a);
        e.irq = m_ctrl[3] & m_flag;
        e.a   = a;
        sbq.push_back(e);
        @(posedge clk);
        model_edge(rst, we, a, d);
        #1;
    endtask

    task automatic idle(input int n, input bit [1:0] a);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, a, $urandom);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            n_checks++;
            if (readData === e.rd) n_pass++;
            else $display("FAIL readData addr=%0d t=%0t got %h expected %h", e.a, $time, readData, e.rd);
            n_checks++;
            if (irq === e.irq) n_pass++;
            else $display("FAIL irq t=%0t got %b expected %b", $time, irq, e.irq);
        end
    end

    initial begin
        int r;
        reset       = 1'b1;
        writeEnable = 1'b0;
        addr        = 2'd0;
        writeData   = 32'd0;
        t           = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;

        // Reset state on every address
        for (int a = 0; a < 4; a++) cycle(1'b1, 1'b0, 2'(a), 32'd0);
        for (int a = 0; a < 4; a++) cycle(1'b0, 1'b0, 2'(a), 32'd0);

        // One-shot expiry, then clearing the flag with a CTRL write
        cycle(1'b0, 1'b1, 2'd1, 32'd3);
        cycle(1'b0, 1'b1, 2'd0, 32'h9);
        idle(8, 2'd2);
        idle(2, 2'd0);
        cycle(1'b0, 1'b1, 2'd0, 32'h0);
        idle(3, 2'd0);

        // Auto-reload pulses
        cycle(1'b0, 1'b1, 2'd1, 32'd2);
        cycle(1'b0, 1'b1, 2'd0, 32'hB);
        idle(14, 2'd2);
        cycle(1'b0, 1'b1, 2'd0, 32'h0);
        idle(3, 2'd2);

        // Pause and restart from PRESET
        cycle(1'b0, 1'b1, 2'd1, 32'd10);
        cycle(1'b0, 1'b1, 2'd0, 32'h1);
        idle(5, 2'd2);
        cycle(1'b0, 1'b1, 2'd0, 32'h0);
        idle(4, 2'd2);
        cycle(1'b0, 1'b1, 2'd0, 32'h1);
        idle(4, 2'd2);

        // Access rules
        cycle(1'b0, 1'b1, 2'd2, 32'h1234);
        cycle(1'b0, 1'b1, 2'd3, 32'hFFFF);
        idle(2, 2'd3);
        idle(1, 2'd2);
        cycle(1'b0, 1'b1, 2'd0, 32'hFFFF_FFF0);
        idle(2, 2'd0);

        // PRESET written mid-count only takes effect at the next reload
        cycle(1'b0, 1'b1, 2'd1, 32'd8);
        cycle(1'b0, 1'b1, 2'd0, 32'h3);
        idle(4, 2'd2);
        cycle(1'b0, 1'b1, 2'd1, 32'd3);
        idle(18, 2'd2);
        cycle(1'b0, 1'b1, 2'd0, 32'h0);

        // PRESET = 0 one-shot
        cycle(1'b0, 1'b1, 2'd1, 32'd0);
        cycle(1'b0, 1'b1, 2'd0, 32'h9);
        idle(6, 2'd2);

        // Reset in the middle of a count
        cycle(1'b0, 1'b1, 2'd1, 32'd20);
        cycle(1'b0, 1'b1, 2'd0, 32'h9);
        idle(5, 2'd2);
        cycle(1'b1, 1'b0, 2'd2, 32'd0);
        for (int a = 0; a < 4; a++) cycle(1'b0, 1'b0, 2'(a), 32'd0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            r = $urandom_range(0, 199);
            if (r < 2)
                cycle(1'b1, 1'b0, 2'($urandom_range(0, 3)), $urandom);
            else if (r < 12)
                cycle(1'b0, 1'b1, 2'd0, $urandom);
            else if (r < 18)
                cycle(1'b0, 1'b1, 2'd1, 32'($urandom_range(0, 12)));
            else if (r < 19)
                cycle(1'b0, 1'b1, 2'd1, $urandom);
            else if (r < 22)
                cycle(1'b0, 1'b1, 2'($urandom_range(2, 3)), $urandom);
            else
                cycle(1'b0, 1'b0, 2'($urandom_range(0, 3)), $urandom);
        end

        reset       = 1'b0;
        writeEnable = 1'b0;
        repeat (3) @(negedge clk);
        if (sbq.size() != 0) begin
            n_checks++;
            $display("FAIL scoreboard_drain pending=%0d expected 0", sbq.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
